ddr_arb_rr: RTL and testbench

Parametrised N-channel DDR arbiter. It collects memory requests from instruction fetch, load and store clients and places them on a single DDR command port. Arbitration is round-robin, one DDR operation is outstanding at a time, burst mode is selected per channel, and redirect can squash flushable channels. It sits between the core's memory clients and the DDR model. It generalises the fixed three-channel arbiter to NUM_CH channels with fairness and completion squashing.

---
 rtl/ddr_arb_rr.sv | 178 +++++++++++++++++
 tb/tb_ddr_arb_rr.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_arb_rr.sv
// Round-robin arbiter that funnels NUM_CH memory clients onto one DDR command port.
// One DDR operation is in flight at a time; flushable channels can have their completion
// squashed by a pipeline redirect while the DDR operation itself always runs to the end.
module ddr_arb_rr #(
  parameter int unsigned       NUM_CH     = 3,
  parameter int unsigned       INDEX_W    = 19,
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       BURST_W    = 512,
  parameter logic [NUM_CH-1:0] BURST_MASK = 'b001,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 'b001
) (
  input  logic                      clock,
  input  logic                      reset_n,
  // Client request side
  input  logic [NUM_CH-1:0]         req_valid,
  input  logic [NUM_CH*INDEX_W-1:0] req_index,
  input  logic [NUM_CH-1:0]         req_write,
  input  logic [NUM_CH*DATA_W-1:0]  req_wmask,
  input  logic [NUM_CH*DATA_W-1:0]  req_wdata,
  output logic [NUM_CH-1:0]         req_ready,
  // Client response side
  output logic [NUM_CH-1:0]         rsp_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [BURST_W-1:0]        rsp_burst_data,
  input  logic                      redirect_valid,
  // DDR command port
  output logic                      ddr_chip_enable,
  output logic [INDEX_W-1:0]        ddr_index,
  output logic                      ddr_write_enable,
  output logic                      ddr_burst_mode,
  output logic [DATA_W-1:0]         ddr_write_mask,
  output logic [DATA_W-1:0]         ddr_write_data,
  input  logic [DATA_W-1:0]         ddr_read_data,
  input  logic [BURST_W-1:0]        ddr_burst_read_data,
  input  logic                      ddr_operation_done,
  input  logic                      ddr_ready
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]     owner_q, owner_d;
  logic                kill_q, kill_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic                write_q, write_d;
  logic                burst_q, burst_d;
  logic [DATA_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CH-1:0]   rsp_done_q, rsp_done_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [BURST_W-1:0]  rsp_burst_q, rsp_burst_d;

  logic [NUM_CH-1:0]   eligible;
  logic                grant_found;
  logic [PtrW-1:0]     grant_idx;
  int unsigned         cand;
  logic                accept;
  logic                owner_flush;
  logic                busy;

  // Round-robin search: first eligible channel strictly after rr_ptr, wrapping around
  always_comb begin
    eligible    = req_valid & ~({NUM_CH{redirect_valid}} & FLUSH_MASK);
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_CH;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PtrW'(cand);
      end
    end
  end

  // Grant is only offered from idle with the DDR able to accept; reset masks it off
  always_comb begin
    accept      = (state_q == StIdle) && ddr_ready && grant_found;
    req_ready   = (accept && reset_n) ? (NUM_CH'(1) << grant_idx) : '0;
    owner_flush = redirect_valid && FLUSH_MASK[owner_q];
  end

  // Next-state logic: request capture, kill tracking and response capture
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    kill_d      = kill_q;
    index_d     = index_q;
    write_d     = write_q;
    burst_d     = burst_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    rsp_done_d  = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_burst_d = rsp_burst_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StIssue;
          rr_ptr_d = grant_idx;
          owner_d  = grant_idx;
          kill_d   = 1'b0;
          index_d  = req_index[grant_idx*INDEX_W +: INDEX_W];
          write_d  = req_write[grant_idx];
          burst_d  = BURST_MASK[grant_idx] & ~req_write[grant_idx];
          // Reads carry no mask/data onto the DDR bus
          wmask_d  = req_write[grant_idx] ? req_wmask[grant_idx*DATA_W +: DATA_W] : '0;
          wdata_d  = req_write[grant_idx] ? req_wdata[grant_idx*DATA_W +: DATA_W] : '0;
        end
      end
      StIssue: begin
        if (owner_flush) kill_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (owner_flush) kill_d = 1'b1;
        if (ddr_operation_done) begin
          rsp_rdata_d = ddr_read_data;
          rsp_burst_d = ddr_burst_read_data;
          // A redirect in the done cycle itself still squashes the response
          if (!(kill_q || owner_flush)) rsp_done_d = NUM_CH'(1) << owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= PtrW'(NUM_CH - 1);
      owner_q     <= '0;
      kill_q      <= 1'b0;
      index_q     <= '0;
      write_q     <= 1'b0;
      burst_q     <= 1'b0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      rsp_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_burst_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      kill_q      <= kill_d;
      index_q     <= index_d;
      write_q     <= write_d;
      burst_q     <= burst_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      rsp_done_q  <= rsp_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_burst_q <= rsp_burst_d;
    end
  end

  // DDR command outputs: held from issue through completion, zero while idle
  always_comb begin
    busy             = (state_q != StIdle);
    ddr_chip_enable  = (state_q == StIssue);
    ddr_index        = busy ? index_q : '0;
    ddr_write_enable = busy & write_q;
    ddr_burst_mode   = busy & burst_q;
    ddr_write_mask   = busy ? wmask_q : '0;
    ddr_write_data   = busy ? wdata_q : '0;
    rsp_done         = rsp_done_q;
    rsp_rdata        = rsp_rdata_q;
    rsp_burst_data   = rsp_burst_q;
  end

endmodule

// File: tb/tb_ddr_arb_rr.sv
// Directed bench for ddr_arb_rr: a table of single transactions plus hand-written
// sequences for redirect, DDR back-pressure, spurious completion and mid-operation reset.
module tb_ddr_arb_rr;

  localparam int NCH = 3;
  localparam int IW  = 19;
  localparam int DW  = 64;
  localparam int BW  = 512;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH*IW-1:0] req_index;
  logic [NCH-1:0]    req_write;
  logic [NCH*DW-1:0] req_wmask;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    rsp_done;
  logic [DW-1:0]     rsp_rdata;
  logic [BW-1:0]     rsp_burst_data;
  logic              redirect_valid;
  logic              ddr_chip_enable;
  logic [IW-1:0]     ddr_index;
  logic              ddr_write_enable;
  logic              ddr_burst_mode;
  logic [DW-1:0]     ddr_write_mask;
  logic [DW-1:0]     ddr_write_data;
  logic [DW-1:0]     ddr_read_data;
  logic [BW-1:0]     ddr_burst_read_data;
  logic              ddr_operation_done;
  logic              ddr_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  ddr_arb_rr #(
    .NUM_CH    (NCH),
    .INDEX_W   (IW),
    .DATA_W    (DW),
    .BURST_W   (BW),
    .BURST_MASK(3'b001),
    .FLUSH_MASK(3'b001)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_index          (req_index),
    .req_write          (req_write),
    .req_wmask          (req_wmask),
    .req_wdata          (req_wdata),
    .req_ready          (req_ready),
    .rsp_done           (rsp_done),
    .rsp_rdata          (rsp_rdata),
    .rsp_burst_data     (rsp_burst_data),
    .redirect_valid     (redirect_valid),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_mask     (ddr_write_mask),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_burst_read_data(ddr_burst_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready)
  );

  typedef struct {
    logic [NCH-1:0] mask;      // channels holding req_valid
    int             grant;     // expected winner
    logic [IW-1:0]  idx;
    logic           wr;
    logic [DW-1:0]  wmask;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;
    int             lat;       // cycles from strobe to ddr_operation_done
    logic           redir;     // pulse redirect in the first wait cycle
    logic           exp_burst;
    logic           exp_done;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winning channel carries the record's payload, the others carry its complement
  task automatic drive_chan(input vec_t v);
    for (int c = 0; c < NCH; c++) begin
      if (c == v.grant) begin
        req_index[c*IW +: IW] = v.idx;
        req_write[c]          = v.wr;
        req_wmask[c*DW +: DW] = v.wmask;
        req_wdata[c*DW +: DW] = v.wdata;
      end else begin
        req_index[c*IW +: IW] = ~v.idx;
        req_write[c]          = ~v.wr;
        req_wmask[c*DW +: DW] = ~v.wmask;
        req_wdata[c*DW +: DW] = ~v.wdata;
      end
    end
    req_valid = v.mask;
  endtask

  // Entered and left on a negedge; the response cycle doubles as the next accept cycle
  task automatic run_txn(input vec_t v);
    logic [NCH-1:0] onehot;
    logic [BW-1:0]  burst;
    onehot = NCH'(1) << v.grant;
    burst  = {4{v.rdata, ~v.rdata}};
    drive_chan(v);
    #1;
    chk("grant", BW'(req_ready), BW'(onehot));
    @(negedge clock);
    chk("strobe", BW'(ddr_chip_enable), BW'(1));
    chk("index", BW'(ddr_index), BW'(v.idx));
    chk("write_en", BW'(ddr_write_enable), BW'(v.wr));
    chk("burst_mode", BW'(ddr_burst_mode), BW'(v.exp_burst));
    chk("wmask", BW'(ddr_write_mask), BW'(v.wr ? v.wmask : 64'h0));
    chk("wdata", BW'(ddr_write_data), BW'(v.wr ? v.wdata : 64'h0));
    chk("ready_busy", BW'(req_ready), BW'(0));
    chk("done_idle", BW'(rsp_done), BW'(0));
    for (int k = 1; k <= v.lat; k++) begin
      @(negedge clock);
      chk("strobe_wait", BW'(ddr_chip_enable), BW'(0));
      chk("index_hold", BW'(ddr_index), BW'(v.idx));
      redirect_valid = v.redir && (k == 1);
      if (k == v.lat) begin
        ddr_operation_done  = 1'b1;
        ddr_read_data       = v.rdata;
        ddr_burst_read_data = burst;
      end
    end
    @(negedge clock);
    ddr_operation_done  = 1'b0;
    redirect_valid      = 1'b0;
    ddr_read_data       = '0;
    ddr_burst_read_data = '0;
    chk("rsp_done", BW'(rsp_done), BW'(v.exp_done ? onehot : 3'b000));
    if (v.exp_done) begin
      chk("rsp_rdata", BW'(rsp_rdata), BW'(v.rdata));
      chk("rsp_burst", rsp_burst_data, burst);
    end
  endtask

  initial begin
    //             mask    g  idx       wr  wmask  wdata  rdata                    lat rd  bm  done
    vecs[0]  = '{3'b010, 1, 19'h01234, 1'b0, 64'h0,  64'h0,  64'hDEADBEEF,         3, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'b001, 0, 19'h00400, 1'b0, 64'h0,  64'h0,  64'h0123456789ABCDEF, 2, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{3'b100, 2, 19'h07F00, 1'b1, 64'hFF, 64'h55, 64'h1111,             1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b111, 0, 19'h00010, 1'b0, 64'h0,  64'h0,  64'hA0,               1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{3'b111, 1, 19'h00011, 1'b1, 64'h0F, 64'hC3, 64'hA1,               1, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{3'b111, 2, 19'h00012, 1'b0, 64'h0,  64'h0,  64'hA2,               1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'b111, 0, 19'h00013, 1'b0, 64'h0,  64'h0,  64'hA3,               1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{3'b111, 1, 19'h00014, 1'b0, 64'h0,  64'h0,  64'hA4,               1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'b111, 2, 19'h00015, 1'b1, 64'h3C, 64'h99, 64'hA5,               1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{3'b001, 0, 19'h00777, 1'b0, 64'h0,  64'h0,  64'hBAD0,             2, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 1, 19'h00888, 1'b0, 64'h0,  64'h0,  64'hC0DE,             2, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b101, 2, 19'h00999, 1'b0, 64'h0,  64'h0,  64'hF00D,             1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'b011, 0, 19'h00AAA, 1'b1, 64'h81, 64'h42, 64'hCAFE,             2, 1'b0, 1'b0, 1'b1};

    reset_n             = 1'b0;
    req_valid           = 3'b111;
    req_index           = '1;
    req_write           = '0;
    req_wmask           = '0;
    req_wdata           = '0;
    redirect_valid      = 1'b0;
    ddr_read_data       = '0;
    ddr_burst_read_data = '0;
    ddr_operation_done  = 1'b0;
    ddr_ready           = 1'b1;

    // Reset state: everything quiet even with requests pending
    repeat (2) @(negedge clock);
    chk("rst_ready", BW'(req_ready), BW'(0));
    chk("rst_strobe", BW'(ddr_chip_enable), BW'(0));
    chk("rst_index", BW'(ddr_index), BW'(0));
    chk("rst_done", BW'(rsp_done), BW'(0));
    reset_n = 1'b1;
    #1;
    chk("first_grant", BW'(req_ready), BW'(3'b001));

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // Redirect in idle hides the only flushable requester
    redirect_valid = 1'b1;
    req_valid      = 3'b001;
    #1;
    chk("redir_idle_ready", BW'(req_ready), BW'(0));
    @(negedge clock);
    chk("redir_idle_strobe", BW'(ddr_chip_enable), BW'(0));
    redirect_valid = 1'b0;
    #1;
    chk("redir_off_ready", BW'(req_ready), BW'(3'b001));
    req_valid = 3'b000;

    // DDR back-pressure blocks every grant
    @(negedge clock);
    ddr_ready = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("ddr_busy_ready", BW'(req_ready), BW'(0));
    @(negedge clock);
    chk("ddr_busy_strobe", BW'(ddr_chip_enable), BW'(0));
    ddr_ready = 1'b1;
    #1;
    chk("ddr_ready_grant", BW'(req_ready), BW'(3'b010));
    req_valid = 3'b000;

    // Completion outside WAIT is ignored
    @(negedge clock);
    ddr_operation_done = 1'b1;
    @(negedge clock);
    ddr_operation_done = 1'b0;
    chk("spurious_done", BW'(rsp_done), BW'(0));
    chk("spurious_strobe", BW'(ddr_chip_enable), BW'(0));

    // Reset during WAIT abandons the operation
    drive_chan(vecs[10]);
    #1;
    chk("mid_grant", BW'(req_ready), BW'(3'b010));
    @(negedge clock);
    chk("mid_strobe", BW'(ddr_chip_enable), BW'(1));
    req_valid = 3'b000;
    @(negedge clock);
    chk("mid_index", BW'(ddr_index), BW'(vecs[10].idx));
    reset_n = 1'b0;
    #1;
    chk("arst_index", BW'(ddr_index), BW'(0));
    chk("arst_strobe", BW'(ddr_chip_enable), BW'(0));
    chk("arst_rdata", BW'(rsp_rdata), BW'(0));
    chk("arst_burst", rsp_burst_data, BW'(0));
    chk("arst_done", BW'(rsp_done), BW'(0));
    @(negedge clock);
    reset_n   = 1'b1;
    req_valid = 3'b111;
    #1;
    chk("post_rst_grant", BW'(req_ready), BW'(3'b001));
    req_valid = 3'b000;
    @(negedge clock);
    chk("post_rst_done", BW'(rsp_done), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
